// File: rtl/io_bus_arbiter.sv
// Two-master arbiter/sequencer for the peripheral I/O bus: chip-select decode, strobe and read-capture timing, req/ack return.
// Define IO_ARB_RR_EN for round-robin arbitration; otherwise master 0 has fixed priority.
module io_bus_arbiter #(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic        sys_clk_i,
    input  logic        sys_rst_i,
    input  logic        m0_req,
    input  logic        m0_rd,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [15:0] m0_wdata,
    input  logic        m1_req,
    input  logic        m1_rd,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [15:0] m1_wdata,
    output logic        m0_ack,
    output logic [15:0] m0_rdata,
    output logic        m0_err,
    output logic        m1_ack,
    output logic [15:0] m1_rdata,
    output logic        m1_err,
    output logic [15:0] io_addr,
    output logic        io_rd,
    output logic        io_wr,
    output logic [15:0] io_dout,
    input  logic [15:0] io_din,
    output logic [3:0]  io_cs,
    output logic        grant,
    output logic        busy
);

    localparam int unsigned CNT_W          = 3;
    localparam bit          MULTI_CYCLE_RD = (RD_LATENCY > 32'd1);
    localparam logic [15:0] UNMAPPED_RDATA = 16'h0666;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STROBE,
        S_WAIT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic        wr;
        logic        rd;
        logic [15:0] addr;
        logic [15:0] wdata;
    } txn_t;

    // Page decode of addr[15:8] onto the one-hot chip select
    function automatic logic [3:0] cs_decode(input logic [7:0] page);
        case (page)
            8'h67:   return 4'b1000;
            8'h68:   return 4'b0100;
            8'h69:   return 4'b0010;
            8'h70:   return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_rd;

    txn_t        w_m0_txn;
    txn_t        w_m1_txn;
    txn_t        w_sel_txn;
    logic        w_pick_m1;
    logic        w_any_req;
    logic [3:0]  w_sel_cs;
    logic        w_long_rd;
    logic        w_to_done;
    logic [15:0] w_rd_capture;

    // A request with both rd and wr set is a write
    assign w_m0_txn  = '{wr: m0_wr, rd: m0_rd & ~m0_wr, addr: m0_addr, wdata: m0_wdata};
    assign w_m1_txn  = '{wr: m1_wr, rd: m1_rd & ~m1_wr, addr: m1_addr, wdata: m1_wdata};
    assign w_any_req = m0_req | m1_req;

`ifdef IO_ARB_RR_EN
    logic r_last;

    assign w_pick_m1 = m1_req & (~m0_req | ~r_last);

    // Last-granted pointer; reset value lets m0 win the first contest
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            r_last <= 1'b1;
        end else if (r_state == S_DONE) begin
            r_last <= grant;
        end
    end
`else
    assign w_pick_m1 = m1_req & ~m0_req;
`endif

    assign w_sel_txn    = w_pick_m1 ? w_m1_txn : w_m0_txn;
    assign w_sel_cs     = cs_decode(w_sel_txn.addr[15:8]);
    assign w_long_rd    = MULTI_CYCLE_RD && r_is_rd && (io_cs != 4'b0000);
    assign w_to_done    = ((r_state == S_STROBE) && !w_long_rd) ||
                          ((r_state == S_WAIT) && (r_cnt == CNT_W'(1)));
    assign w_rd_capture = (io_cs != 4'b0000) ? io_din : UNMAPPED_RDATA;

    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_rd  <= 1'b0;
            io_addr  <= '0;
            io_dout  <= '0;
            io_cs    <= '0;
            io_rd    <= 1'b0;
            io_wr    <= 1'b0;
            grant    <= 1'b0;
            busy     <= 1'b0;
            m0_ack   <= 1'b0;
            m1_ack   <= 1'b0;
            m0_err   <= 1'b0;
            m1_err   <= 1'b0;
            m0_rdata <= '0;
            m1_rdata <= '0;
        end else begin
            io_rd  <= 1'b0;
            io_wr  <= 1'b0;
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            m0_err <= 1'b0;
            m1_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state <= S_STROBE;
                        r_is_rd <= w_sel_txn.rd;
                        grant   <= w_pick_m1;
                        busy    <= 1'b1;
                        io_addr <= w_sel_txn.addr;
                        io_dout <= w_sel_txn.wdata;
                        io_cs   <= w_sel_cs;
                        // Unmapped or no-op requests complete without a strobe
                        io_wr   <= w_sel_txn.wr & (|w_sel_cs);
                        io_rd   <= w_sel_txn.rd & (|w_sel_cs);
                    end
                end
                S_STROBE: begin
                    if (w_long_rd) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_W'(RD_LATENCY - 32'd1);
                    end else begin
                        r_state <= S_DONE;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_is_rd <= 1'b0;
                    busy    <= 1'b0;
                    io_addr <= '0;
                    io_dout <= '0;
                    io_cs   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Completion: ack, err and read data land together in DONE
            if (w_to_done) begin
                if (grant) begin
                    m1_ack <= 1'b1;
                    m1_err <= ~|io_cs;
                    if (r_is_rd) begin
                        m1_rdata <= w_rd_capture;
                    end
                end else begin
                    m0_ack <= 1'b1;
                    m0_err <= ~|io_cs;
                    if (r_is_rd) begin
                        m0_rdata <= w_rd_capture;
                    end
                end
            end
        end
    end

endmodule

// File: doc/io_bus_arbiter.md
# io_bus_arbiter

Two-master arbiter and sequencer for the SoC peripheral I/O bus (mult at 0x67xx, div 0x68xx, uart 0x69xx, ram 0x70xx). It lets the J1 core (master 0) and a second master (debug/DMA port, master 1) share the single addr/rd/wr/dout bus. It decodes chip-selects, times the read-data capture, and returns data with a req/ack handshake. It sits between the masters and the peripheral instances; `io_din` is the peripheral read-data mux output.

## Interface
- `RD_LATENCY`, default 1: cycles from strobe to capture of `io_din`. Legal range 1–7.
- `sys_clk_i`  in  1  system clock; all logic on rising edge.
- `sys_rst_i`  in  1  reset, asynchronous, active-low.
- `m0_req`, `m1_req`  in  1  access request; held high until the matching `mX_ack`.
- `m0_rd`, `m1_rd`  in  1  read access.
- `m0_wr`, `m1_wr`  in  1  write access.
- `m0_addr`, `m1_addr`  in  16  I/O address.
- `m0_wdata`, `m1_wdata`  in  16  write data.
- `m0_ack`, `m1_ack`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  16  read data, valid from the ack cycle and held until that master's next ack.
- `m0_err`, `m1_err`  out  1  valid with ack; high if the address is unmapped.
- `io_addr`  out  16  shared bus address.
- `io_rd`, `io_wr`  out  1  one-cycle bus strobes.
- `io_dout`  out  16  shared bus write data.
- `io_din`  in  16  peripheral read data.
- `io_cs`  out  4  one-hot chip select: [3] mult 0x67, [2] div 0x68, [1] uart 0x69, [0] ram 0x70.
- `grant`  out  1  master currently owning the bus (0/1).
- `busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, STROBE, WAIT, DONE.
- IDLE:
  - If any `req` is high, latch the winner's rd/wr/addr/wdata, set `grant`, and go to STROBE.
  - A request with both rd and wr high is treated as a write; rd is ignored.
- STROBE:
  - Drive the latched address and data. `io_cs` is decoded from `addr[15:8]`.
  - Assert `io_wr` or `io_rd` for exactly this one cycle.
  - Go to WAIT if this is a read and `RD_LATENCY` > 1; otherwise go to DONE.
- WAIT: down-counter loaded with `RD_LATENCY`−1; go to DONE when it reaches 0.
- DONE:
  - For a read, capture `io_din` into `mX_rdata` (holding the address and `io_cs`), then pulse `mX_ack`.
  - Next state is IDLE.
  - A req/ack pair may restart arbitration from DONE only after one IDLE cycle.
- `io_addr`, `io_cs` and `io_dout` hold their values from STROBE through DONE. They are 0 in IDLE.
- Unmapped address (`io_cs`=0): no strobe is issued. The transaction still completes with `err`=1, and a read returns 16'h0666.
- Request with neither rd nor wr: no strobe is issued; ack is returned with `err`=0 and rdata unchanged.
- Arbitration: round-robin (see Configuration). The last-granted pointer updates in DONE.

## Timing
- Request high in IDLE at edge N: STROBE at N+1, then DONE at N+1+`RD_LATENCY` for reads and N+2 for writes.
- Ack pulse length is 1 cycle. The master may drop `req` in the cycle after ack.
- Simultaneous requests in the same cycle are resolved by the arbitration rule. The loser keeps `req` high and is served next.
- A `req` that drops before its ack: the transaction already granted completes anyway, and the ack is still pulsed.
- Reset, including mid-transaction:
  - All outputs go to 0 asynchronously: `io_*`, ack, err, rdata=16'h0000, `grant`=0, `busy`=0.
  - State returns to IDLE, the RR pointer to "last=m1" (so m0 wins first), and the counter to 0.
  - No strobe occurs during reset or on the first cycle after release.

## Configuration
- `IO_ARB_RR_EN` defined: round-robin. On simultaneous requests, the master not granted last wins.
- Not defined: fixed priority. m0 (J1) always wins simultaneous requests, and the pointer logic is absent.

## Test plan
- m0 write 0x6702 data 0x1234, m1 idle: `io_wr` pulses at N+1 with `io_cs`=4'b1000, `io_dout`=0x1234; `m0_ack` at N+2 with `err`=0.
- m1 read 0x7003 with `RD_LATENCY`=3 and `io_din`=0xBEEF: `io_rd` at N+1; `m1_ack` at N+4 with `m1_rdata`=0xBEEF.
- Both masters request reads repeatedly: with `IO_ARB_RR_EN`, grants alternate 0,1,0,1; without it, m0 wins every contest and m1 is served only when m0 is idle.
- m0 read 0x5500: no strobe, `io_cs`=0, `m0_ack` at N+2 with `err`=1 and `rdata`=0x0666.
- Reset asserted during WAIT of a read: all outputs are 0 immediately and no ack is seen. After release, a fresh m0 write completes with normal N+2 timing.
